dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
- Data-memory responder for the MEM pipe stage. It takes the stage's load/store request, formats it for a multi-cycle word-wide memory port, and drives memReady back to the stall controller.
- While an access is in flight, memReady stays low so the stall controller freezes the pipeline. memReady returns high for exactly one cycle when load data or store completion is available.
- Also detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: BUSY cycles allowed without mem_ack before the access is aborted with bus_error.
- CNT_WIDTH, 8: width of the timeout counter; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- memRead  in  1  MEM-stage load request.
- memWrite  in  1  MEM-stage store request.
- addr  in  32  byte address from the EX/MEM register.
- wdata  in  32  store data, right-aligned.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rdata  out  32  formatted load result; valid while memReady=1 in DONE.
- memReady  out  1  0 = stall pipeline; 1 = no access pending, or access complete.
- misaligned  out  1  pulse in DONE for a misaligned access.
- bus_error  out  1  pulse in DONE for a timed-out access.
- mem_req  out  1  memory request; level, held until mem_ack.
- mem_we  out  1  1 = write.
- mem_addr  out  30  word address (addr[31:2]).
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte enables (0000 for reads).
- mem_ack  in  1  memory completion; one-cycle pulse.
- mem_rdata  in  32  read word; valid with mem_ack.

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to IDLE; the counter clears.
  - mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, rdata, misaligned and bus_error are all 0.
  - memReady reads 1 while reset is low.
  - A reset during BUSY aborts the access; mem_req is 0 after that edge.
- States: IDLE, BUSY, DONE.
- memReady (combinational):
  - IDLE: equals !(memRead|memWrite).
  - BUSY: 0.
  - DONE: 1.
- IDLE with memRead or memWrite high:
  - Capture addr[1:0], funct3, direction, and the formatted address/data/strobe.
  - If memWrite=1, the access is a write and memRead is ignored.
  - Aligned access: go to BUSY; mem_req=1 from the next cycle.
  - Misaligned access (H with addr[0]=1, W with addr[1:0]!=00): go directly to DONE with misaligned=1 and rdata=0. No bus cycle is issued.
- Store formatting:
  - SB: wstrb = 0001 << addr[1:0]; data = {4{wdata[7:0]}}.
  - SH: wstrb = 0011 << addr[1:0]; data = {2{wdata[15:0]}}.
  - SW: wstrb = 1111; data = wdata.
- BUSY:
  - mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb hold stable; inputs are ignored.
  - The counter increments each cycle.
  - mem_ack=1: mem_req drops and state goes to DONE. For a read, rdata is registered from mem_rdata selected by the captured addr[1:0]: B/H sign-extended, BU/HU zero-extended, W passed through.
  - Counter reaches TIMEOUT_CYCLES with no ack: mem_req drops, state goes to DONE, bus_error=1, rdata=0.
- DONE:
  - Lasts exactly one cycle; memReady=1 and the pipeline advances.
  - Next state is IDLE unconditionally. A back-to-back request is seen in IDLE on the following cycle.
  - misaligned and bus_error clear on leaving DONE.
- Latency:
  - With ack in the first BUSY cycle, memReady is low for 2 cycles and high on the 3rd.
  - Each extra wait cycle adds one stall cycle.
  - Misaligned accesses stall exactly 1 cycle.
- Late acks: a mem_ack arriving outside BUSY is ignored.

Test Plan:
- LW, addr=0x100, mem_ack in first BUSY cycle, mem_rdata=0xDEADBEEF → memReady 0,0,1; mem_addr=0x40; rdata=0xDEADBEEF in DONE.
- LB, addr=0x103, mem_rdata=0x80123456 → rdata=0xFFFFFF80. Repeat as LBU → rdata=0x00000080. LH at 0x102 → 0xFFFF8012.
- SB, addr=0x202, wdata=0x000000AB → mem_we=1, wstrb=0100, mem_wdata=0xABABABAB. SH at 0x202 → wstrb=1100. Both memRead and memWrite high → write.
- LW at 0x101 → no mem_req; memReady 0 then 1; misaligned=1 for one cycle; rdata=0.
- Read with no mem_ack, TIMEOUT_CYCLES=4 → mem_req high for 4 cycles, then bus_error=1 and memReady=1 in DONE. A later ack is ignored.
- Reset low in the 2nd BUSY cycle → mem_req=0 and memReady=1 after that edge. A new LW after reset release completes normally.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage load/store responder for a word-wide multi-cycle memory port
module dmem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_WIDTH      = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata,
   output logic        memReady,
   output logic        misaligned,
   output logic        bus_error,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t               state;
   logic [CNT_WIDTH-1:0] cnt;
   logic [1:0]           cap_off;
   logic [2:0]           cap_funct3;
   logic                 req;
   logic                 is_mis;
   logic [31:0]          fmt_wdata;
   logic [3:0]           fmt_wstrb;
   logic [7:0]           ld_byte;
   logic [15:0]          ld_half;
   logic [31:0]          load_data;

   assign req    = memRead | memWrite;
   assign is_mis = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1] && addr[1:0] != 2'b00);

   // Stores are lane-replicated so the strobe alone picks the target byte lanes.
   always_comb begin
      fmt_wdata = wdata;
      fmt_wstrb = 4'b1111;
      if (!funct3[1]) begin
         if (funct3[0]) begin
            fmt_wdata = {2{wdata[15:0]}};
            fmt_wstrb = 4'b0011 << addr[1:0];
         end else begin
            fmt_wdata = {4{wdata[7:0]}};
            fmt_wstrb = 4'b0001 << addr[1:0];
         end
      end
   end

   always_comb begin
      case (cap_off)
         2'd0:    ld_byte = mem_rdata[7:0];
         2'd1:    ld_byte = mem_rdata[15:8];
         2'd2:    ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      ld_half = cap_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      if (cap_funct3[1])
         load_data = mem_rdata;
      else if (cap_funct3[0])
         load_data = {{16{~cap_funct3[2] & ld_half[15]}}, ld_half};
      else
         load_data = {{24{~cap_funct3[2] & ld_byte[7]}}, ld_byte};
   end

   always_comb begin
      memReady = 1'b1;
      if (reset) begin
         case (state)
            IDLE:    memReady = ~req;
            BUSY:    memReady = 1'b0;
            default: memReady = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         cap_off    <= 2'b00;
         cap_funct3 <= 3'b000;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= 4'b0000;
         rdata      <= '0;
         misaligned <= 1'b0;
         bus_error  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  cap_off    <= addr[1:0];
                  cap_funct3 <= funct3;
                  mem_we     <= memWrite;
                  mem_addr   <= addr[31:2];
                  mem_wdata  <= memWrite ? fmt_wdata : 32'h0;
                  mem_wstrb  <= memWrite ? fmt_wstrb : 4'b0000;
                  cnt        <= '0;
                  if (is_mis) begin
                     state      <= DONE;
                     misaligned <= 1'b1;
                     rdata      <= '0;
                  end else begin
                     state   <= BUSY;
                     mem_req <= 1'b1;
                  end
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= DONE;
                  rdata   <= mem_we ? 32'h0 : load_data;
               end else if (cnt == CNT_LAST) begin
                  mem_req   <= 1'b0;
                  state     <= DONE;
                  bus_error <= 1'b1;
                  rdata     <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state      <= IDLE;
               misaligned <= 1'b0;
               bus_error  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
